// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Brief    : Depth calculation and parameter legality shared by the FIFOs.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    function automatic int fifo_depth(input int array_size);
        return 1 << array_size;
    endfunction

    function automatic bit fifo_params_legal(input int array_size,
                                             input int af_level,
                                             input int ae_level);
        return (array_size >= 2) && (ae_level >= 0) &&
               (ae_level < af_level) && (af_level <= fifo_depth(array_size));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : fifo_mem
// Brief    : Simple dual-port RAM; combinational read (FWFT) or registered read.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE  = 8,
    parameter int ARRAY_SIZE = 4,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [ARRAY_SIZE-1:0] w_addr,
    input  logic [DATA_SIZE-1:0]  w_data,
    input  logic                  r_en,
    input  logic [ARRAY_SIZE-1:0] r_addr,
    output logic [DATA_SIZE-1:0]  r_data
);

    localparam int c_depth = fifo_depth(ARRAY_SIZE);

    logic [DATA_SIZE-1:0] r_mem [c_depth];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_en) begin
            r_mem[w_addr] <= w_data;
        end
    end

    if (FWFT != 0) begin : g_fwft_read
        assign r_data = r_mem[r_addr];
    end else begin : g_reg_read
        logic [DATA_SIZE-1:0] r_rd_data;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_rd_data <= '0;
            end else if (r_en) begin
                r_rd_data <= r_mem[r_addr];
            end
        end

        assign r_data = r_rd_data;
    end

endmodule
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with occupancy, thresholds, flush, error flags.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE  = 8,
    parameter int ARRAY_SIZE = 4,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  err_clr,
    input  logic                  w_req,
    input  logic [DATA_SIZE-1:0]  w_data,
    input  logic                  r_req,
    output logic [DATA_SIZE-1:0]  r_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ARRAY_SIZE:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                c_depth     = fifo_depth(ARRAY_SIZE);
    localparam logic [ARRAY_SIZE:0] c_depth_cnt = (ARRAY_SIZE+1)'(c_depth);
    localparam logic [ARRAY_SIZE:0] c_af_cnt    = (ARRAY_SIZE+1)'(AF_LEVEL);
    localparam logic [ARRAY_SIZE:0] c_ae_cnt    = (ARRAY_SIZE+1)'(AE_LEVEL);
    localparam logic [ARRAY_SIZE:0] c_one       = (ARRAY_SIZE+1)'(1);

    if (!fifo_params_legal(ARRAY_SIZE, AF_LEVEL, AE_LEVEL)) begin : g_param_check
        $error("sync_fifo: illegal ARRAY_SIZE/AF_LEVEL/AE_LEVEL combination");
    end

    logic [ARRAY_SIZE:0] r_wbin, r_rbin, r_count;
    logic                r_full, r_empty, r_almost_full, r_almost_empty;
    logic                r_overflow, r_underflow;

    logic                w_wr_ok, w_rd_ok;
    logic [ARRAY_SIZE:0] w_wbin_nxt, w_rbin_nxt, w_count_nxt;

    assign w_wr_ok = w_req & ~r_full  & ~flush;
    assign w_rd_ok = r_req & ~r_empty & ~flush;

    always_comb begin
        w_wbin_nxt = r_wbin;
        w_rbin_nxt = r_rbin;
        if (flush) begin
            w_wbin_nxt = '0;
            w_rbin_nxt = '0;
        end else begin
            if (w_wr_ok) w_wbin_nxt = r_wbin + c_one;
            if (w_rd_ok) w_rbin_nxt = r_rbin + c_one;
        end
        // Modular difference covers pointer wrap without a special case.
        w_count_nxt = w_wbin_nxt - w_rbin_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wbin         <= '0;
            r_rbin         <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_wbin         <= w_wbin_nxt;
            r_rbin         <= w_rbin_nxt;
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == c_depth_cnt);
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= c_af_cnt);
            r_almost_empty <= (w_count_nxt <= c_ae_cnt);
        end
    end

    // A fresh error outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_req && r_full && !flush) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (r_req && r_empty && !flush) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    fifo_mem #(
        .DATA_SIZE  (DATA_SIZE),
        .ARRAY_SIZE (ARRAY_SIZE),
        .FWFT       (FWFT)
    ) u_mem (
        .clk    (clk),
        .rst    (rst),
        .w_en   (w_wr_ok),
        .w_addr (r_wbin[ARRAY_SIZE-1:0]),
        .w_data (w_data),
        .r_en   (w_rd_ok),
        .r_addr (r_rbin[ARRAY_SIZE-1:0]),
        .r_data (r_data)
    );

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo
// Brief    : Randomised scoreboard bench for sync_fifo (registered-read mode).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

    localparam int c_depth = 16;
    localparam int c_af    = 14;
    localparam int c_ae    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       err_clr = 1'b0;
    logic       w_req = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic       r_req = 1'b0;
    logic [7:0] r_data;
    logic       full, empty, almost_full, almost_empty;
    logic [4:0] count;
    logic       overflow, underflow;

    sync_fifo #(
        .DATA_SIZE  (8),
        .ARRAY_SIZE (4),
        .FWFT       (0),
        .AF_LEVEL   (c_af),
        .AE_LEVEL   (c_ae)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .err_clr      (err_clr),
        .w_req        (w_req),
        .w_data       (w_data),
        .r_req        (r_req),
        .r_data       (r_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a plain queue, sticky errors as bits.
    int mq[$];
    int exp_q[$];
    bit m_ovf = 1'b0;
    bit m_udf = 1'b0;

    int s_vec = 0;
    int s_err = 0;
    int m_vec = 0;
    int m_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        s_vec++;
        if (act !== exp) begin
            s_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        chk("count",        32'(count),        32'(mq.size()));
        chk("full",         32'(full),         32'(mq.size() == c_depth));
        chk("empty",        32'(empty),        32'(mq.size() == 0));
        chk("almost_full",  32'(almost_full),  32'(mq.size() >= c_af));
        chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= c_ae));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_udf));
    endtask

    // One clock of stimulus; called just after a rising edge.
    task automatic step(input bit wr, input logic [7:0] d, input bit rd,
                        input bit fl, input bit ec);
        bit was_full, was_empty, wa, ra;
        w_req = wr; w_data = d; r_req = rd; flush = fl; err_clr = ec;
        was_full  = (mq.size() == c_depth);
        was_empty = (mq.size() == 0);
        wa = wr && !was_full  && !fl;
        ra = rd && !was_empty && !fl;
        if (fl) begin
            mq.delete();
        end else begin
            if (ra) exp_q.push_back(mq.pop_front());
            if (wa) mq.push_back(int'(d));
        end
        if (wr && was_full && !fl) m_ovf = 1'b1;
        else if (ec)               m_ovf = 1'b0;
        if (rd && was_empty && !fl) m_udf = 1'b1;
        else if (ec)                m_udf = 1'b0;
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst = 1'b0; w_req = 1'b0; r_req = 1'b0; flush = 1'b0; err_clr = 1'b0;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        check_state();
        chk("r_data_reset", 32'(r_data), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: a read accepted at a rising edge presents its word by the falling edge.
    initial begin
        bit fire;
        int e;
        forever begin
            @(posedge clk);
            fire = rst && r_req && !empty && !flush;
            @(negedge clk);
            if (fire) begin
                m_vec++;
                if (exp_q.size() == 0) begin
                    m_err++;
                    $display("FAIL r_data_unexpected: got %0h expected no read (t=%0t)", r_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (32'(r_data) !== 32'(e[7:0])) begin
                        m_err++;
                        $display("FAIL r_data: got %0h expected %0h (t=%0t)", r_data, e[7:0], $time);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit wr, rd, fl, ec;
        #12;
        check_state();
        chk("r_data_reset", 32'(r_data), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Fill to full, then overflow and error-clear priority.
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEF, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Drain, then underflow.
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Streaming at count 8 long enough for the pointers to wrap.
        for (int i = 0; i < 8; i++)  step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);

        // Flush beats simultaneous read and write at count 5.
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Random traffic: write-heavy then read-heavy to reach both boundaries.
        for (int i = 0; i < 400; i++) begin
            if (i < 200) begin
                wr = ($urandom_range(0, 9) < 7);
                rd = ($urandom_range(0, 9) < 3);
            end else begin
                wr = ($urandom_range(0, 9) < 3);
                rd = ($urandom_range(0, 9) < 7);
            end
            fl = ($urandom_range(0, 39) == 0);
            ec = ($urandom_range(0, 15) == 0);
            step(wr, 8'($urandom), rd, fl, ec);
        end

        // Asynchronous reset mid-burst at count 9.
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        async_reset();
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle();
        idle();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", s_vec + m_vec, s_err + m_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO: the same-clock successor to our dual-clock FIFO, for buffering between blocks that share one clock. Adds occupancy count, programmable almost-full/almost-empty thresholds, selectable first-word-fall-through (FWFT) or registered-read mode, synchronous flush and sticky overflow/underflow error flags.

## Interface
- data_size, 8, word width in bits
- array_size, 4, address width; DEPTH = 2^array_size (legal: array_size >= 2)
- fwft, 0, 1 = FWFT (r_data combinational from head entry); 0 = registered read
- af_level, 14, almost_full asserts when count >= af_level (legal: ae_level < af_level <= DEPTH)
- ae_level, 2, almost_empty asserts when count <= ae_level (legal: ae_level >= 0)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of contents
- err_clr  in  1  clears sticky error flags
- w_req  in  1  write request
- w_data  in  data_size  write data
- r_req  in  1  read request
- r_data  out  data_size  read data
- full, empty  out  1  registered status
- almost_full, almost_empty  out  1  registered thresholds
- count  out  array_size+1  occupancy, 0..DEPTH
- overflow, underflow  out  1  sticky error flags

## Operation
- Binary pointers wbin, rbin, array_size+1 bits each; address = low array_size bits; MSB distinguishes wrap; count = wbin - rbin (modulo 2^(array_size+1)).
- Write accepted: w_req & ~full & ~flush. Stores w_data at wbin, wbin+1.
- Read accepted: r_req & ~empty & ~flush. rbin+1.
- Write and read both accepted in one cycle: count unchanged. Write while full is dropped, even with a simultaneous read; no pass-through.
- w_req while full (flush low): write dropped, overflow set. r_req while empty (flush low): rbin and r_data held, underflow set.
- Flags derive from next count and register on the same edge as the pointers: full = (count==DEPTH), empty = (count==0), almost_full, almost_empty per parameters.
- flush: wbin = rbin = 0, count = 0, empty = almost_empty = 1, full = almost_full = 0. Overrides w_req/r_req in that cycle; sets no error flags. Memory contents not cleared. In fwft=0 mode r_data is held.
- err_clr clears overflow and underflow. A new error in the same cycle wins; the flag stays set.
- fwft=1: r_data = mem[rbin addr] at all times. Valid whenever empty=0. Undefined while empty.
- fwft=0: r_data register loads mem[rbin addr] on an accepted read. Holds otherwise.
- Wrap-around: pointers roll from 2^(array_size+1)-1 to 0 with no special case.

## Timing
- Reset values: count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, r_data=0 in fwft=0 mode. Memory is not reset.
- Write accepted at edge k: count, empty, almost_* update at edge k. In fwft=1, data is visible on r_data during cycle k+1.
- Read latency: fwft=1, 0 cycles (head word present while empty=0). fwft=0, 1 cycle (data valid after the accepting edge).
- full at edge k blocks writes from cycle k+1. A read at edge k clears full at that same edge, so a write can be accepted in cycle k+1.
- Reset assertion mid-operation clears all state immediately (asynchronous). Deassertion is synchronous to clk (external synchroniser).

## Structure
- Package fifo_pkg holds the DEPTH computation (1 << array_size) and elaboration-time parameter legality checks; it is shared with the dual-clock FIFO.
- One sub-module: fifo_mem. Simple dual-port RAM: synchronous write; combinational read for fwft=1, registered read for fwft=0. Pointer, count and flag logic stays in sync_fifo.

## Test plan
- Reset, then write 0x01..0x10 (16 words, defaults) -> almost_full after the 14th write, full after the 16th, count=16. A 17th w_req sets overflow, count stays 16.
- Read 16 words from full -> data 0x01..0x10 in order: same cycle for fwft=1, one cycle later for fwft=0. almost_empty at count=2, empty at 0. A further r_req sets underflow.
- Continuous simultaneous read and write at count=8 for 40 cycles -> count stays 8, pointers wrap past 31->0, data order intact.
- flush asserted with w_req=r_req=1 at count=5 -> next cycle count=0, empty=1, no error flags, no write stored.
- err_clr concurrent with an overflow write -> overflow remains 1. err_clr alone next cycle -> overflow=0.
- rst pulled low mid-burst at count=9 -> all outputs go to reset values immediately. After release, the first write/read returns the new data.
